// File: rtl/core_pkg.sv
// Shared core types and sizes for the integer datapath.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: optional write forwarding, x0 and reset forced to zero.
module reg_file_rd_port #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int ADDR_W = core_pkg::REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              wr_en,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        data = rf_data;
        if (BYPASS != 0 && wr_en && rd_idx == idx) begin
            data = wr_data;
        end
        // x0 and the reset window win over any forwarded value
        if (!rst_n || idx == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 storage, two async read ports, one write port.
module reg_file #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int NUM_REGS  = core_pkg::NUM_REGS,
    parameter int ADDR_W    = core_pkg::REG_ADDR_W,
    parameter int WR_BYPASS = 0
) (
    input  logic              clk_i,
    input  logic              regrst_i,
    input  logic [ADDR_W-1:0] RS1_i,
    input  logic [ADDR_W-1:0] RS2_i,
    input  logic [ADDR_W-1:0] RD_i,
    input  logic [XLEN-1:0]   WR_i,
    input  logic              RWR_EN_i,
    output logic [XLEN-1:0]   R1_o,
    output logic [XLEN-1:0]   R2_o
);

    logic [XLEN-1:0] regs [1:NUM_REGS-1];
    logic [XLEN-1:0] raw1;
    logic [XLEN-1:0] raw2;
    logic            wr_ok;

    assign wr_ok = RWR_EN_i & regrst_i;

    // per-register compare keeps an X index from hitting any entry
    always_ff @(posedge clk_i or negedge regrst_i) begin
        if (!regrst_i) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (RWR_EN_i && RD_i == ADDR_W'(i)) begin
                    regs[i] <= WR_i;
                end
            end
        end
    end

    always_comb begin
        raw1 = '0;
        raw2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (RS1_i == ADDR_W'(i)) raw1 = regs[i];
            if (RS2_i == ADDR_W'(i)) raw2 = regs[i];
        end
    end

    reg_file_rd_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .BYPASS (WR_BYPASS)
    ) u_rd1 (
        .rst_n   (regrst_i),
        .idx     (RS1_i),
        .rf_data (raw1),
        .rd_idx  (RD_i),
        .wr_data (WR_i),
        .wr_en   (wr_ok),
        .data    (R1_o)
    );

    reg_file_rd_port #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .BYPASS (WR_BYPASS)
    ) u_rd2 (
        .rst_n   (regrst_i),
        .idx     (RS2_i),
        .rf_data (raw2),
        .rd_idx  (RD_i),
        .wr_data (WR_i),
        .wr_en   (wr_ok),
        .data    (R2_o)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed plus random checks of reg_file against an array model, both bypass modes.
module tb_reg_file;

    logic        clk_i;
    logic        regrst_i;
    logic [4:0]  RS1_i;
    logic [4:0]  RS2_i;
    logic [4:0]  RD_i;
    logic [31:0] WR_i;
    logic        RWR_EN_i;
    logic [31:0] R1_o;
    logic [31:0] R2_o;
    logic [31:0] r1b;
    logic [31:0] r2b;

    int n_checks;
    int n_fail;
    logic [31:0] m [32];

    reg_file dut (
        .clk_i    (clk_i),
        .regrst_i (regrst_i),
        .RS1_i    (RS1_i),
        .RS2_i    (RS2_i),
        .RD_i     (RD_i),
        .WR_i     (WR_i),
        .RWR_EN_i (RWR_EN_i),
        .R1_o     (R1_o),
        .R2_o     (R2_o)
    );

    reg_file #(.WR_BYPASS(1)) dut_byp (
        .clk_i    (clk_i),
        .regrst_i (regrst_i),
        .RS1_i    (RS1_i),
        .RS2_i    (RS2_i),
        .RD_i     (RD_i),
        .WR_i     (WR_i),
        .RWR_EN_i (RWR_EN_i),
        .R1_o     (r1b),
        .R2_o     (r2b)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byp_exp(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (RWR_EN_i && RD_i != 5'd0 && RD_i == rs) return WR_i;
        return m[rs];
    endfunction

    task automatic step(input logic [4:0] rd, input logic [31:0] d,
                        input logic en, input logic [4:0] s1,
                        input logic [4:0] s2);
        @(negedge clk_i);
        RD_i = rd;
        WR_i = d;
        RWR_EN_i = en;
        RS1_i = s1;
        RS2_i = s2;
        #1;
        check("pre_r1", R1_o, m[s1]);
        check("pre_r2", R2_o, m[s2]);
        check("byp_r1", r1b, byp_exp(s1));
        check("byp_r2", r2b, byp_exp(s2));
        @(posedge clk_i);
        if (en && rd != 5'd0) m[rd] = d;
        #1;
        check("post_r1", R1_o, m[s1]);
        check("post_r2", R2_o, m[s2]);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        regrst_i = 1'b0;
        RS1_i = '0;
        RS2_i = '0;
        RD_i = '0;
        WR_i = '0;
        RWR_EN_i = 1'b0;
        repeat (3) @(posedge clk_i);
        for (int i = 0; i < 32; i++) begin
            RS1_i = 5'(i);
            RS2_i = 5'(31 - i);
            #1;
            check("rst_r1", R1_o, 32'h0);
            check("rst_r2", R2_o, 32'h0);
        end
        @(negedge clk_i);
        regrst_i = 1'b1;

        step(5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5);
        step(5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        check("x0_zero", R1_o, 32'h0);
        step(5'd7, 32'h00001234, 1'b0, 5'd7, 5'd5);
        check("x7_keep", R1_o, 32'h0);

        for (int i = 1; i < 32; i++) begin
            step(5'(i), 32'(i) * 32'h01010101, 1'b1, 5'(i), 5'(i - 1));
        end
        step(5'd0, 32'h0, 1'b0, 5'd1, 5'd31);
        check("pair_1", R1_o, 32'h01010101);
        check("pair_31", R2_o, 32'h1F1F1F1F);
        step(5'd0, 32'h0, 1'b0, 5'd15, 5'd16);
        check("pair_15", R1_o, 32'h0F0F0F0F);
        check("pair_16", R2_o, 32'h10101010);

        for (int k = 0; k < 300; k++) begin
            step(5'($urandom_range(0, 31)), $urandom, 1'($urandom),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        step(5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3);
        @(negedge clk_i);
        RD_i = 5'd3;
        WR_i = 32'h55555555;
        RWR_EN_i = 1'b1;
        #2;
        check("pre_async", R1_o, 32'hA5A5A5A5);
        regrst_i = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        #1;
        check("async_r1", R1_o, 32'h0);
        check("async_byp", r1b, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_blk_wr", R1_o, 32'h0);
        check("rst_blk_byp", r2b, 32'h0);
        @(negedge clk_i);
        #2;
        regrst_i = 1'b1;
        #1;
        check("rel_pre", R1_o, 32'h0);
        @(posedge clk_i);
        m[3] = 32'h55555555;
        #1;
        check("rel_first_wr", R1_o, m[3]);
        step(5'd9, 32'h0BADF00D, 1'b1, 5'd9, 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
